// File: rtl/core_alu_pkg.sv
// Shared types for the multi-cycle ALU: operation encoding, FSM state and op-class helpers.
package core_alu_pkg;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_BEQ    = 5'd10,
        ALU_BNE    = 5'd11,
        ALU_BLT    = 5'd12,
        ALU_BGE    = 5'd13,
        ALU_BLTU   = 5'd14,
        ALU_BGEU   = 5'd15,
        ALU_MUL    = 5'd16,
        ALU_MULH   = 5'd17,
        ALU_MULHSU = 5'd18,
        ALU_MULHU  = 5'd19,
        ALU_DIV    = 5'd20,
        ALU_DIVU   = 5'd21,
        ALU_REM    = 5'd22,
        ALU_REMU   = 5'd23
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_single_op(alu_op_t op);
        return op <= ALU_BGEU;
    endfunction

    function automatic logic is_muldiv_op(alu_op_t op);
        return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                          ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

endpackage

// File: rtl/core_alu_muldiv.sv
// Iterative RV32M-style multiply (shift-add) and divide (restoring), one bit per cycle.
module core_alu_muldiv
    import core_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  alu_op_t         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    logic            busy_q;
    logic [CW-1:0]   cnt_q;
    alu_op_t         op_q;
    logic            neg_q;
    logic            neg_rem_q;
    logic            div0_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] hi_d;
    logic [XLEN-1:0] lo_d;

    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            is_div;
    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic [2*XLEN-1:0] prod;

    // Both engines work on magnitudes; signs are reapplied when the result is read.
    always_comb begin
        sign_a = a[XLEN-1] && (op inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM});
        sign_b = b[XLEN-1] && (op inside {ALU_MULH, ALU_DIV, ALU_REM});
        a_mag  = sign_a ? -a : a;
        b_mag  = sign_b ? -b : b;
    end

    assign is_div = op_q inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    assign done   = busy_q && (cnt_q == CW'(XLEN - 1));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        hi_d    = hi_q;
        lo_d    = lo_q;
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        shifted = {hi_q, lo_q[XLEN-1]};
        diff    = shifted - {1'b0, b_q};
        if (is_div) begin
            if (!diff[XLEN]) begin
                hi_d = diff[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_d = shifted[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_d = sum[XLEN:1];
            lo_d = {sum[0], lo_q[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so all registers update together.
        if (rst) begin
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            op_q      <= ALU_ADD;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else if (start) begin
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            op_q      <= op;
            neg_q     <= sign_a ^ sign_b;
            neg_rem_q <= sign_a;
            div0_q    <= (b == '0);
            a_q       <= a;
            b_q       <= b_mag;
            hi_q      <= '0;
            lo_q      <= a_mag;
        end else if (busy_q) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + 1'b1;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

    always_comb begin
        result = '0;
        prod   = {hi_q, lo_q};
        if (neg_q) begin
            prod = -prod;
        end
        case (op_q)
            ALU_MUL:                          result = prod[XLEN-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU:  result = prod[2*XLEN-1:XLEN];
            ALU_DIV, ALU_DIVU:  result = div0_q ? '1 : (neg_q ? -lo_q : lo_q);
            ALU_REM, ALU_REMU:  result = div0_q ? a_q : (neg_rem_q ? -hi_q : hi_q);
            default:            result = '0;
        endcase
    end

endmodule

// File: rtl/core_alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes; define CORE_ALU_MULDIV_EN to add the
// iterative RV32M multiply/divide ops (otherwise those codes complete as illegal).
module core_alu_mc
    import core_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_cmp,
    output logic            out_err
);

    localparam int SHW = $clog2(XLEN);
`ifdef CORE_ALU_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    state_t          state_q;
    state_t          state_d;
    alu_op_t         op;
    logic            accept;
    logic            op_md;
    logic            op_legal;
    logic            md_sel_q;
    logic            cmp_q;
    logic            err_q;
    logic [XLEN-1:0] result_q;
    logic            md_done;
    logic [XLEN-1:0] md_result;

    logic [SHW-1:0]  shamt;
    logic            eq;
    logic            lt_s;
    logic            lt_u;
    logic [XLEN-1:0] alu_res;
    logic            alu_cmp;

    assign op       = alu_op_t'(in_op);
    assign accept   = in_valid && in_ready;
    assign op_md    = MD_EN && is_muldiv_op(op);
    assign op_legal = is_single_op(op) || op_md;

`ifdef CORE_ALU_MULDIV_EN
    core_alu_muldiv #(.XLEN(XLEN)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (accept && op_md),
        .op     (op),
        .a      (in_a),
        .b      (in_b),
        .done   (md_done),
        .result (md_result)
    );
`else
    assign md_done   = 1'b0;
    assign md_result = '0;
`endif

    always_comb begin
        shamt   = in_b[SHW-1:0];
        eq      = (in_a == in_b);
        lt_s    = ($signed(in_a) < $signed(in_b));
        lt_u    = (in_a < in_b);
        alu_res = '0;
        alu_cmp = 1'b0;
        case (op)
            ALU_ADD:  alu_res = in_a + in_b;
            ALU_SUB:  alu_res = in_a - in_b;
            ALU_SLL:  alu_res = in_a << shamt;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, lt_u};
            ALU_XOR:  alu_res = in_a ^ in_b;
            ALU_SRL:  alu_res = in_a >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(in_a) >>> shamt);
            ALU_OR:   alu_res = in_a | in_b;
            ALU_AND:  alu_res = in_a & in_b;
            ALU_BEQ:  alu_cmp = eq;
            ALU_BNE:  alu_cmp = !eq;
            ALU_BLT:  alu_cmp = lt_s;
            ALU_BGE:  alu_cmp = !lt_s;
            ALU_BLTU: alu_cmp = lt_u;
            ALU_BGEU: alu_cmp = !lt_u;
            default: begin
                alu_res = '0;
                alu_cmp = 1'b0;
            end
        endcase
        if (op inside {ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU}) begin
            alu_res = {{(XLEN-1){1'b0}}, alu_cmp};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = op_md ? ST_BUSY : ST_DONE;
            ST_BUSY: if (md_done) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // in_ready is gated by rst so nothing is offered acceptance while reset is held.
    always_comb begin
        in_ready  = (state_q == ST_IDLE) && !rst;
        out_valid = (state_q == ST_DONE);
    end

    // Single-cycle results are captured at acceptance and held through DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            md_sel_q <= 1'b0;
            result_q <= '0;
            cmp_q    <= 1'b0;
            err_q    <= 1'b0;
        end else if (accept) begin
            md_sel_q <= op_md;
            result_q <= (op_legal && !op_md) ? alu_res : '0;
            cmp_q    <= op_legal && !op_md && alu_cmp;
            err_q    <= !op_legal;
        end
    end

    assign out_result = md_sel_q ? md_result : result_q;
    assign out_cmp    = cmp_q;
    assign out_err    = err_q;

endmodule

// File: tb/tb_core_alu_mc.sv
// Scoreboard bench for core_alu_mc (XLEN=32); build with CORE_ALU_MULDIV_EN to cover M ops.
module tb_core_alu_mc;
    import core_alu_pkg::*;

    localparam int XLEN = 32;
`ifdef CORE_ALU_MULDIV_EN
    localparam int MD_GAP = XLEN;
`endif

    typedef struct {
        string           name;
        logic [XLEN-1:0] res;
        logic            cmp;
        logic            err;
        int              acc;
        int              gap;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      in_op;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic            out_cmp;
    logic            out_err;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t sb_q[$];
    bit   first_seen = 1'b0;
    bit   chk_idle   = 1'b0;

    core_alu_mc #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_cmp    (out_cmp),
        .out_err    (out_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares the head of the scoreboard every cycle the DUT presents a result.
    always @(negedge clk) begin
        if (chk_idle && !rst) begin
            check("idle_after_handshake", {in_ready, out_valid}, 2'b10);
            chk_idle = 1'b0;
        end
        if (!rst && out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_out_valid", out_valid, 1'b0);
            end else begin
                if (!first_seen) begin
                    check({sb_q[0].name, "_latency"}, 64'(cyc - sb_q[0].acc), 64'(sb_q[0].gap));
                    first_seen = 1'b1;
                end
                check({sb_q[0].name, "_result"}, out_result, sb_q[0].res);
                check({sb_q[0].name, "_cmp"}, out_cmp, sb_q[0].cmp);
                check({sb_q[0].name, "_err"}, out_err, sb_q[0].err);
                check({sb_q[0].name, "_in_ready"}, in_ready, 1'b0);
                if (out_ready) begin
                    void'(sb_q.pop_front());
                    first_seen = 1'b0;
                    chk_idle   = 1'b1;
                end
            end
        end
    end

    // Called at posedge+1; offers one op and pushes its expected response at acceptance.
    task automatic issue(input string name, input alu_op_t op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] res,
                         input logic cmp, input logic err, input int gap);
        exp_t e;
        int   n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            check({name, "_accept_timeout"}, in_ready, 1'b1);
            return;
        end
        e.name = name;
        e.res  = res;
        e.cmp  = cmp;
        e.err  = err;
        e.acc  = cyc + 1;
        e.gap  = gap;
        sb_q.push_back(e);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_op    = 5'($urandom_range(0, 31));
        in_a     = $urandom();
        in_b     = $urandom();
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb_q.size() != 0) begin
            check("drain_timeout", 64'(sb_q.size()), 64'd0);
        end
    endtask

    task automatic apply_reset_midop(input string name);
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb_q.delete();
        first_seen = 1'b0;
        chk_idle   = 1'b0;
        check({name, "_out_valid"}, out_valid, 1'b0);
        check({name, "_out_result"}, out_result, '0);
        check({name, "_in_ready"}, in_ready, 1'b0);
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_result", out_result, '0);
        check("rst_out_cmp", out_cmp, 1'b0);
        check("rst_out_err", out_err, 1'b0);
        rst = 1'b0;
        #1;
        check("release_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        issue("add",      ALU_ADD,  32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1'b0, 0);
        issue("add_wrap", ALU_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 0);
        issue("sub",      ALU_SUB,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0, 0);
        issue("sra",      ALU_SRA,  32'h8000_0000, 32'h0000_0021, 32'hC000_0000, 1'b0, 1'b0, 0);
        issue("srl",      ALU_SRL,  32'h8000_0000, 32'h0000_0021, 32'h4000_0000, 1'b0, 1'b0, 0);
        issue("sll31",    ALU_SLL,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 1'b0, 0);
        issue("sll32",    ALU_SLL,  32'h0000_0001, 32'h0000_0020, 32'h0000_0001, 1'b0, 1'b0, 0);
        issue("slt",      ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 0);
        issue("sltu",     ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 0);
        issue("xor",      ALU_XOR,  32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5, 1'b0, 1'b0, 0);
        issue("or",       ALU_OR,   32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1'b0, 1'b0, 0);
        issue("and",      ALU_AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0, 0);
        issue("beq",      ALU_BEQ,  32'h0000_0003, 32'h0000_0003, 32'h0000_0001, 1'b1, 1'b0, 0);
        issue("bne",      ALU_BNE,  32'h0000_0003, 32'h0000_0003, 32'h0000_0000, 1'b0, 1'b0, 0);
        issue("bltu",     ALU_BLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 0);
        issue("blt",      ALU_BLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b1, 1'b0, 0);
        issue("bge",      ALU_BGE,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 0);
        issue("bgeu",     ALU_BGEU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b1, 1'b0, 0);
        issue("illegal24", alu_op_t'(5'd24), 32'h1234_5678, 32'h1, 32'h0, 1'b0, 1'b1, 0);
        issue("illegal31", alu_op_t'(5'd31), 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b1, 0);
`ifdef CORE_ALU_MULDIV_EN
        issue("mul",      ALU_MUL,    32'd6,         32'd7,         32'd42,        1'b0, 1'b0, MD_GAP);
        issue("mulh",     ALU_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, MD_GAP);
        issue("mulhsu",   ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, MD_GAP);
        issue("mulhu",    ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, MD_GAP);
        issue("div_by0",  ALU_DIV,    32'd7,         32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0, MD_GAP);
        issue("rem_by0",  ALU_REM,    32'd7,         32'd0,         32'd7,         1'b0, 1'b0, MD_GAP);
        issue("div_neg",  ALU_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 1'b0, MD_GAP);
        issue("rem_neg",  ALU_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, 1'b0, MD_GAP);
        issue("div_ovf",  ALU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, MD_GAP);
        issue("rem_ovf",  ALU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, MD_GAP);
        issue("divu",     ALU_DIVU,   32'd100,       32'd7,         32'd14,        1'b0, 1'b0, MD_GAP);
        issue("remu",     ALU_REMU,   32'd100,       32'd7,         32'd2,         1'b0, 1'b0, MD_GAP);
`else
        issue("mul_off",  ALU_MUL,    32'd6,         32'd7,         32'h0,         1'b0, 1'b1, 0);
        issue("divu_off", ALU_DIVU,   32'd100,       32'd7,         32'h0,         1'b0, 1'b1, 0);
`endif
        drain();

        // Result held under back-pressure while a competing op is offered and ignored.
        out_ready = 1'b0;
        issue("hold_add", ALU_ADD, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 0);
        in_valid = 1'b1;
        in_op    = ALU_SUB;
        in_a     = 32'hDEAD_BEEF;
        in_b     = 32'h0000_0001;
        repeat (5) @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        repeat (5) @(posedge clk);
        #1;

        out_ready = 1'b0;
        issue("rst_done_add", ALU_ADD, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0, 0);
        @(posedge clk);
        #1;
        apply_reset_midop("rst_in_done");
        issue("after_rst_done", ALU_ADD, 32'd7, 32'd8, 32'd15, 1'b0, 1'b0, 0);
        drain();

`ifdef CORE_ALU_MULDIV_EN
        issue("rst_busy_divu", ALU_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, MD_GAP);
        repeat (9) @(posedge clk);
        #1;
        apply_reset_midop("rst_in_busy");
        issue("after_rst_busy", ALU_ADD, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1'b0, 0);
        drain();
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/core_alu_mc.md
CORE_ALU_MC -- requirements
Module: core_alu_mc

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values are powers of two from 8 to 64.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous to clk, active-high.
REQ-004 SHALL have port in_valid  input  1  operation offered.
REQ-005 SHALL have port in_ready  output  1  block can accept an operation.
REQ-006 SHALL have port in_op  input  5  operation code (alu_op_t from package).
REQ-007 SHALL have port in_a  input  XLEN  operand A (rs1 or pc).
REQ-008 SHALL have port in_b  input  XLEN  operand B (rs2 or immediate; decoder selects).
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port out_result  output  XLEN  result value.
REQ-012 SHALL have port out_cmp  output  1  branch condition true.
REQ-013 SHALL have port out_err  output  1  op code illegal or not compiled in.

Function
REQ-014 SHALL implement FSM IDLE/BUSY/DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 SHALL accept an operation on a clk edge with in_valid&in_ready, latching in_op, in_a and in_b.
REQ-016 Single-cycle ops (ADD SUB SLL SLT SLTU XOR SRL SRA OR AND BEQ BNE BLT BGE BLTU BGEU) SHALL go IDLE->DONE; out_valid rises the cycle after acceptance.
REQ-017 Shift amount SHALL be in_b[log2(XLEN)-1:0]; SRA sign-fills, SRL/SLL zero-fill.
REQ-018 SLT/BLT/BGE SHALL compare signed; SLTU/BLTU/BGEU SHALL compare unsigned; ADD/SUB wrap modulo 2^XLEN.
REQ-019 Branch ops SHALL drive out_cmp=condition and out_result=zero-extended condition; all other ops drive out_cmp=0.
REQ-020 DONE SHALL hold out_result/out_cmp/out_err stable until out_valid&out_ready, then go to IDLE; no new acceptance in the same cycle.
REQ-021 Illegal op codes SHALL complete as single-cycle with out_result=0, out_cmp=0, out_err=1.
REQ-022 Multi-cycle ops (REQ-027) SHALL go IDLE->BUSY; iteration counter counts XLEN cycles; out_valid rises exactly XLEN+1 cycles after acceptance.
REQ-023 in_* inputs SHALL be ignored outside IDLE.

Reset
REQ-024 With rst=1 at a clk edge, state SHALL become IDLE, out_valid=0, out_result=0, out_cmp=0, out_err=0, iteration counter=0.
REQ-025 Reset during BUSY or DONE SHALL abandon the operation with no result ever presented.
REQ-026 in_ready SHALL be 0 while rst=1 and 1 in the first cycle after reset release.

Configuration
REQ-027 Macro CORE_ALU_MULDIV_EN defined: SHALL add MUL MULH MULHSU MULHU (iterative shift-add) and DIV DIVU REM REMU (iterative restoring), one bit per cycle, RV32M semantics.
REQ-028 With the macro: divide by zero SHALL give quotient all-ones, remainder = in_a; signed most-negative / -1 SHALL give quotient = in_a, remainder 0.
REQ-029 Macro undefined: the eight M op codes SHALL be treated as illegal per REQ-021, and no iterative datapath SHALL be synthesized.

Structure
REQ-030 Package core_alu_pkg SHALL hold alu_op_t encoding (all 24 codes) and FSM state typedef.
REQ-031 Iterative multiply/divide SHALL be sub-module core_alu_muldiv (start/done handshake), instantiated only under CORE_ALU_MULDIV_EN.

Verification (XLEN=32)
REQ-032 ADD a=0x000000F0 b=0x0000000F -> out_result=0x000000FF, out_valid the cycle after acceptance, out_err=0.
REQ-033 SRA a=0x80000000 b=0x00000021 -> 0xC0000000; BLTU a=0xFFFFFFFF b=1 -> out_cmp=0; BLT same -> out_cmp=1.
REQ-034 out_ready held 0 for 5 cycles in DONE -> result stable, in_ready=0 throughout; out_ready=1 -> IDLE next cycle.
REQ-035 With macro: DIV a=7 b=0 -> 0xFFFFFFFF after 33 cycles; REM a=0x80000000 b=0xFFFFFFFF -> 0; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
REQ-036 Without macro: MUL -> out_err=1, out_result=0 in one cycle.
REQ-037 rst=1 in BUSY cycle 10 of DIVU -> IDLE next cycle, out_valid never asserted, next ADD correct.
